wb_dmi_host: RTL

//  Wishbone-slave-to-DMI initiator: drives the DTM-side DMI port of the debug module (dm_top dmi_* pins) from a system bus.

---
 rtl/wb_dmi_host_if.sv | 26 ++
 rtl/wb_dmi_host.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_dmi_host_if.sv
// Wishbone bus bundle: 32-bit classic/pipelined Wishbone with stall.
// Latency: none, signal bundle only.
// Backpressure: stall from slave to master; ack/err terminate a cycle.
// Ports (master view): cyc, stb, we, adr[31:0], sel[3:0], dat_m[31:0] out; dat_s[31:0], ack, err, stall in.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_dmi_host.sv
// Wishbone slave that turns each bus access into one DMI request/response on the DM's DTM-side port, plus a local CSR.
// Latency: DMI access = 1 (accept) + req handshake + resp wait + 1 (ack) cycles, min 4; CSR/illegal accesses answer in 2.
// Backpressure: stall high whenever not IDLE; dmi_req held stable until dmi_req_ready; aborts with err after TimeoutCycles.
// Ports: clk, rst_n (async, active low); wbs (wb_if.slave); dmi_rst_n; dmi_req_valid/ready/dmi_req;
//        dmi_resp_valid/ready/dmi_resp. dmi_req = {addr[6:0], op[1:0], data[31:0]}, dmi_resp = {data[31:0], resp[1:0]},
//        bit-compatible with dm::dmi_req_t / dm::dmi_resp_t so this file carries no package dependency.
module wb_dmi_host #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned DmiRstCycles  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_if.slave         wbs,
  output logic        dmi_rst_n,
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [40:0] dmi_req,
  input  logic        dmi_resp_valid,
  output logic        dmi_resp_ready,
  input  logic [33:0] dmi_resp
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
  localparam int unsigned RstW   = $clog2(DmiRstCycles + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles);
  localparam logic [RstW-1:0]   RstLoad  = RstW'(DmiRstCycles);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP_ACK,
    ST_RESP_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [40:0]       req_q, req_d;
  logic              req_valid_q, req_valid_d;
  logic              resp_ready_q, resp_ready_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic [31:0]       dat_s_q, dat_s_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic              aborted_q, aborted_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;

  logic hit_dmi;
  logic hit_csr;
  logic respond;
  logic timer_hit;
  logic take_timeout;

  // Byte lanes within a word carry no meaning here.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wbs.adr[1:0];

  assign hit_dmi = (wbs.adr[31:9] == 23'd0);
  assign hit_csr = (wbs.adr[31:2] == 30'h80);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_valid_d  = req_valid_q;
    resp_ready_d = resp_ready_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    dat_s_d      = '0;
    timer_d      = timer_q;
    timeout_d    = timeout_q;
    aborted_d    = aborted_q;
    rst_cnt_d    = (rst_cnt_q != '0) ? rst_cnt_q - RstW'(1) : rst_cnt_q;
    take_timeout = 1'b0;
    // A master that dropped cyc at any point in this access gets no termination.
    respond      = wbs.cyc && !aborted_q;
    timer_hit    = (timer_q == TimerMax);

    unique case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        aborted_d = 1'b0;
        if (wbs.cyc && wbs.stb) begin
          if (hit_csr) begin
            state_d = ST_RESP_ACK;
            ack_d   = 1'b1;
            if (wbs.we) begin
              if (wbs.dat_m[0]) timeout_d = 1'b0;
              if (wbs.dat_m[1]) rst_cnt_d = RstLoad;
            end else begin
              dat_s_d = {31'd0, timeout_q};
            end
          end else if (!hit_dmi || (rst_cnt_q != '0) || (wbs.we && (wbs.sel != 4'hF))) begin
            // Partial writes cannot be expressed on DMI; DM is also unusable while held in reset.
            state_d = ST_RESP_ERR;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
            req_d       = {wbs.adr[8:2], (wbs.we ? 2'd2 : 2'd1), wbs.dat_m};
          end
        end
      end

      ST_REQ: begin
        timer_d = timer_q + TimerW'(1);
        if (!wbs.cyc) aborted_d = 1'b1;
        if (timer_hit) begin
          take_timeout = 1'b1;
        end else if (dmi_req_ready) begin
          req_valid_d  = 1'b0;
          resp_ready_d = 1'b1;
          state_d      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_d = timer_q + TimerW'(1);
        if (!wbs.cyc) aborted_d = 1'b1;
        // A response arriving on the timeout cycle still counts.
        if (dmi_resp_valid) begin
          resp_ready_d = 1'b0;
          if (dmi_resp[1:0] == 2'd0) begin
            state_d = ST_RESP_ACK;
            ack_d   = respond;
            dat_s_d = respond ? dmi_resp[33:2] : 32'd0;
          end else begin
            state_d = ST_RESP_ERR;
            err_d   = respond;
          end
        end else if (timer_hit) begin
          take_timeout = 1'b1;
        end
      end

      ST_RESP_ACK, ST_RESP_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abandon the DMI transaction and reset the DM so a late response cannot leak into the next access.
    if (take_timeout) begin
      timeout_d    = 1'b1;
      rst_cnt_d    = RstLoad;
      req_valid_d  = 1'b0;
      resp_ready_d = 1'b0;
      state_d      = ST_RESP_ERR;
      err_d        = respond;
    end

    stall_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      dat_s_q      <= '0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      stall_q      <= stall_d;
      dat_s_q      <= dat_s_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      aborted_q    <= aborted_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign dmi_rst_n      = rst_n & (rst_cnt_q == '0);
  assign dmi_req_valid  = req_valid_q;
  assign dmi_req        = req_q;
  assign dmi_resp_ready = resp_ready_q;
  assign wbs.ack        = ack_q;
  assign wbs.err        = err_q;
  assign wbs.stall      = stall_q;
  assign wbs.dat_s      = dat_s_q;

endmodule
